dmem_result_uart: RTL
=====================

# dmem_result_uart

Post-run result streamer for the matrix-multiplication core. When the core raises END, the block reads a contiguous window of data memory one word at a time. It transmits each 16-bit word high byte first as UART 8N1 frames on `tx`. It sits downstream of the core's data memory read port and gives the only off-chip view of the product matrix.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clk cycles per UART bit (≥2).
- `ADDR_W`, 16: data memory address width.
- `DATA_W`, 16: data memory word width (fixed at 16 for 2-byte framing).

Ports:
- `clk` in 1: single system clock, all logic on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `END` in 1: core completion flag; rising edge starts a dump.
- `start_addr` in ADDR_W: first result word address, sampled at trigger.
- `word_count` in 16: number of words to send, sampled at trigger.
- `mem_addr` out ADDR_W: data memory read address.
- `mem_read` out 1: one-cycle read strobe.
- `mem_data` in DATA_W: read data, valid exactly one cycle after `mem_read`.
- `tx` out 1: UART serial line, idle high.
- `busy` out 1: high from trigger until `done`.
- `done` out 1: one-cycle pulse after the last stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `mem_read`=0, `mem_addr`=0; FSM in IDLE; `END` edge register cleared to 0.
- Trigger: registered `END_q`; trigger when `END & ~END_q` in IDLE. If `END` is held high, it does not retrigger. An `END` edge outside IDLE is ignored.
- On trigger: latch `addr`←`start_addr` and `remaining`←`word_count`, set `busy`=1. If `word_count`==0, go to DONE. Otherwise go to READ.
- READ (1 cycle): `mem_read`=1, `mem_addr`=`addr`. Go to CAPTURE.
- CAPTURE (1 cycle): `word`←`mem_data`, `byte_sel`←HI. Go to FRAME.
- FRAME: shift 10 bits, each held for CLKS_PER_BIT cycles. The order is start bit 0, then data[0..7] LSB first, then stop bit 1. HI byte = `word[15:8]`, LO byte = `word[7:0]`.
- End of the HI frame: the LO frame starts the next cycle, back-to-back with no idle gap.
- End of the LO frame: `remaining`−1 and `addr`+1. The address wraps modulo 2^ADDR_W, so 0xFFFF→0x0000. If `remaining` was 1, go to DONE; else go to READ.
- DONE (1 cycle): `done`=1, `busy`=0 on exit. Return to IDLE.
- `mem_read` is asserted only in READ, never in any other state.
- `RESET` mid-dump: the next edge forces all reset values, and `tx` returns high immediately, truncating any partial frame. A new dump requires a fresh `END` rising edge after reset.

## Timing
- Trigger cycle T: `busy` is high from T+1.
- First `mem_read` is at T+1. The start bit begins at T+3.
- Per word: 2 + 20·CLKS_PER_BIT cycles, from READ to the end of the LO stop bit.
- Total for N≥1 words: `done` is high at T+1+N·(2+20·CLKS_PER_BIT). For N=0, `done` is high at T+1.
- Bit boundaries: `tx` changes only at multiples of CLKS_PER_BIT after frame start; jitter is 0 cycles.
- Between words, `tx` stays 1 for the 2 cycles of READ/CAPTURE.
- `busy` deasserts the same cycle `done` falls. A new trigger is accepted one cycle after `done` at the earliest.

## Test plan
- Basic dump: CLKS_PER_BIT=4, mem[0x20]=0x1234, mem[0x21]=0xABCD, start_addr=0x20, word_count=2, pulse END. Required: decoded bytes are 0x12,0x34,0xAB,0xCD, and `done` is high exactly 1+2·(2+80)=165 cycles after the trigger cycle.
- Zero count: word_count=0 with END rising. Required: no `mem_read` and `tx` constant 1, with a `done` pulse at T+1 and `busy` high for exactly 1 cycle.
- Level/retrigger: hold END high for 500 cycles, then pulse it again mid-dump. Required: exactly one dump of word_count words and no extra `mem_read`.
- Address wrap: start_addr=0xFFFF, word_count=2, mem[0xFFFF]=0x00FF, mem[0x0000]=0x8001. Required: `mem_addr` sequence 0xFFFF then 0x0000, and bytes 0x00,0xFF,0x80,0x01.
- Reset mid-frame: assert RESET for 1 cycle during the data bit 3 of the first frame. Required: next cycle `tx`=1, `busy`=0, `mem_read`=0, and no `done`. A subsequent END edge restarts the dump from start_addr.
- Framing check: 0x5555 at CLKS_PER_BIT=3. Required: each bit is held exactly 3 cycles, stop bit=1, and the LO start bit follows the HI stop bit with no gap.

Source files
------------

// File: rtl/dmem_result_uart.sv
// dmem_result_uart: when the core raises END, reads a window of data memory
// word by word and sends each 16-bit word on a UART 8N1 line, high byte first.
module dmem_result_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              END,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_FRAME,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              end_q;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [DATA_W-1:0] word;
    logic              byte_lo;
    logic [3:0]        bit_idx;
    logic [CNT_W-1:0]  clk_cnt;

    logic              trigger;
    logic              bit_end;
    logic              frame_end;
    logic [7:0]        cur_byte;
    logic [2:0]        data_idx;

    // Memory read port: mem_read is a one-cycle strobe with no back-pressure;
    // the memory returns mem_data exactly one cycle later, taken in CAPTURE.
    assign mem_addr  = addr;

    assign trigger   = (state == S_IDLE) && END && !end_q;
    assign bit_end   = (clk_cnt == CNT_MAX);
    assign frame_end = bit_end && (bit_idx == 4'd9);
    assign cur_byte  = byte_lo ? word[7:0] : word[15:8];
    assign data_idx  = 3'(bit_idx - 4'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore outputs; tx is a pure decode of the frame position.
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        tx         = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (trigger) begin
                    state_next = (word_count == 16'd0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_read   = 1'b1;
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_next = S_FRAME;
            end
            S_FRAME: begin
                if (bit_idx == 4'd0) begin
                    tx = 1'b0;
                end else if (bit_idx == 4'd9) begin
                    tx = 1'b1;
                end else begin
                    tx = cur_byte[data_idx];
                end
                if (frame_end && byte_lo) begin
                    state_next = (remaining == 16'd1) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: END edge detect, window bookkeeping, word capture and bit timing.
    always_ff @(posedge clk) begin
        if (RESET) begin
            end_q     <= 1'b0;
            addr      <= '0;
            remaining <= '0;
            word      <= '0;
            byte_lo   <= 1'b0;
            bit_idx   <= '0;
            clk_cnt   <= '0;
        end else begin
            end_q <= END;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        addr      <= start_addr;
                        remaining <= word_count;
                    end
                end
                S_CAPTURE: begin
                    word    <= mem_data;
                    byte_lo <= 1'b0;
                    bit_idx <= '0;
                    clk_cnt <= '0;
                end
                S_FRAME: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            // Low frame follows the high frame with no idle gap.
                            bit_idx <= '0;
                            if (!byte_lo) begin
                                byte_lo <= 1'b1;
                            end else begin
                                remaining <= remaining - 16'd1;
                                addr      <= addr + ADDR_W'(1);
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
